inst_packer: RTL and testbench

Streaming RV32I instruction encoder: takes decoded fields plus a signed immediate and packs them into a 32-bit instruction word. It is the inverse of the immediate generator: for legal input, feeding `inst` back through immediate generation returns the original immediate. It sits between the boot/test-program loader and instruction memory, and emits an incrementing word address with each instruction. A 2-stage valid/ready pipeline with range checking and an error-halt state machine.

---
 rtl/definitions_pkg.sv | 34 +++
 rtl/imm_pack.sv | 47 ++++
 rtl/inst_packer.sv | 165 ++++++++++++++++
 tb/tb_inst_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared types, opcodes and immediate bounds for the instruction packer
package definitions_pkg;

  // Immediate layout selector; values above U_TYPE are undefined.
  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    STORE  = 3'd1,
    BRANCH = 3'd2,
    JAL    = 3'd3,
    U_TYPE = 3'd4
  } imm_e;

  // Control state: RUN accepts entries, HALT waits for addr_clr.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Base opcodes of the formats the loader emits.
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  // Signed range limits of the encodable immediates.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - scatters a signed immediate into its instruction bit positions and range-checks it
module imm_pack
  import definitions_pkg::*;
(
  input  imm_e        imm_sel,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        illegal
);

  logic signed [31:0] simm;

  assign simm = imm;

  // Place immediate bits per format; out-of-range values still pack their truncated bits.
  always_comb begin
    imm_bits = '0;
    illegal  = 1'b1;
    case (imm_sel)
      I_TYPE: begin
        imm_bits = {imm[11:0], 20'b0};
        illegal  = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      STORE: begin
        imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        illegal  = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      BRANCH: begin
        imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        illegal  = (simm < IMM13_MIN) || (simm > IMM13_MAX) || imm[0];
      end
      JAL: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        illegal  = (simm < IMM21_MIN) || (simm > IMM21_MAX) || imm[0];
      end
      U_TYPE: begin
        imm_bits = {imm[31:12], 12'b0};
        illegal  = (imm[11:0] != 12'b0);
      end
      default: begin
        imm_bits = '0;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_packer.sv
// rtl/inst_packer.sv - two-stage RV32I instruction encoder with address counter and error halt
module inst_packer
  import definitions_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter bit                STOP_ON_ERR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fmt_r,
  input  imm_e              imm_sel,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              halted,
  output logic [7:0]        err_count,
  input  logic              addr_clr
);

  state_e      state_q, state_d;
  logic [31:0] imm_bits;
  logic        imm_illegal;
  logic        use_rd, use_rs1, use_rs2, use_f3;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic        s1_valid, s1_err;
  logic [31:0] s1_inst;
  logic        s2_ready, s1_leave, err_event, err_drop, s2_load;
  logic        in_fire, out_fire;

  imm_pack u_imm_pack (
    .imm_sel  (imm_sel),
    .imm      (imm),
    .imm_bits (imm_bits),
    .illegal  (imm_illegal)
  );

  // Which register/funct fields each immediate format carries; the rest stay zero.
  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    case (imm_sel)
      I_TYPE: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
      end
      STORE, BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
      end
      JAL, U_TYPE: use_rd = 1'b1;
      default: use_rd = 1'b0;
    endcase
  end

  // Assemble the word entering S1; R-type bypasses the immediate path entirely.
  always_comb begin
    pack_inst = imm_bits | {7'b0, rs2 & {5{use_rs2}}, rs1 & {5{use_rs1}},
                            funct3 & {3{use_f3}}, rd & {5{use_rd}}, opcode};
    pack_err  = imm_illegal;
    if (fmt_r) begin
      pack_inst = {funct7, rs2, rs1, funct3, rd, opcode};
      pack_err  = 1'b0;
    end
  end

  assign s2_ready  = !out_valid || out_ready;
  assign s1_leave  = s1_valid && s2_ready;
  assign err_event = s1_leave && s1_err;
  assign err_drop  = err_event && STOP_ON_ERR;
  assign s2_load   = s1_leave && !err_drop;
  assign in_ready  = (state_q == ST_RUN) && (!s1_valid || s2_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign halted    = (state_q == ST_HALT);

  // S1: capture the packed word and its legality verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
      s1_err   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_inst  <= pack_inst;
      s1_err   <= pack_err;
    end else if (s1_leave) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: output register; holds while the consumer stalls, dropped errors never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_inst  <= s1_inst;
      out_err   <= s1_err;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Word address advances only on a real output transfer; addr_clr wins for the next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= BASE_ADDR;
    end else if (addr_clr) begin
      out_addr <= BASE_ADDR;
    end else if (out_fire) begin
      out_addr <= out_addr + ADDR_W'(4);
    end
  end

  // Saturating illegal-entry counter, cleared together with the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (addr_clr) begin
      err_count <= '0;
    end else if (err_event && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a dropped illegal entry halts intake until addr_clr.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (err_drop) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
    if (addr_clr) state_d = ST_RUN;
  end

endmodule

// File: tb/tb_inst_packer.sv
// tb/tb_inst_packer.sv - directed and round-trip bench for inst_packer
`timescale 1ns/1ps
module tb_inst_packer;
  import definitions_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam logic [3:0]  NE_BASE = 4'hC;
  localparam int          NRAND   = 10000;

  typedef struct packed {
    bit          r;
    logic [2:0]  sel;
    logic [31:0] imm;
    bit          bad;
  } bnd_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic fmt_r = 1'b0;
  imm_e imm_sel = I_TYPE;
  logic [6:0] opcode = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [31:0] imm = '0;
  logic out_ready = 1'b0;
  logic addr_clr = 1'b0;

  logic in_ready, out_valid, out_err, halted;
  logic [31:0] out_inst, out_addr;
  logic [7:0] err_count;
  logic ne_in_ready, ne_out_valid, ne_out_err, ne_halted;
  logic [31:0] ne_out_inst;
  logic [3:0] ne_out_addr;
  logic [7:0] ne_err_count;

  int tests = 0;
  int fails = 0;
  bnd_t bnd [19];
  exp_t q [$];

  always #5 clk = ~clk;

  inst_packer #(.ADDR_W(32), .BASE_ADDR(BASE), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .fmt_r(fmt_r),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .halted(halted),
    .err_count(err_count), .addr_clr(addr_clr)
  );

  inst_packer #(.ADDR_W(4), .BASE_ADDR(NE_BASE), .STOP_ON_ERR(1'b0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ne_in_ready), .fmt_r(fmt_r),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(ne_out_valid), .out_ready(out_ready),
    .out_inst(ne_out_inst), .out_addr(ne_out_addr), .out_err(ne_out_err), .halted(ne_halted),
    .err_count(ne_err_count), .addr_clr(addr_clr)
  );

  task automatic set_fields(input bit fr, input logic [2:0] sel, input logic [6:0] op,
                            input logic [4:0] rd_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm_i);
    fmt_r = fr; imm_sel = imm_e'(sel); opcode = op; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i;
    funct3 = f3; funct7 = f7; imm = imm_i;
  endtask

  task automatic drive;
    int n;
    n = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (!in_ready) begin fails++; $display("FAIL drive_timeout in_ready=%b want 1", in_ready); end
    else begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic wait_out;
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    tests++;
    if (!out_valid) begin fails++; $display("FAIL wait_out_timeout out_valid=%b want 1", out_valid); end
  endtask

  task automatic pulse_clr;
    @(posedge clk); #1 addr_clr = 1'b1;
    @(posedge clk); #1 addr_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_inst !== 32'h0) begin fails++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got %b want 0", out_err); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    tests++; if (out_addr !== BASE) begin fails++; $display("FAIL reset_out_addr got %h want %h", out_addr, BASE); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_i_type;
    pulse_clr;
    out_ready = 1'b1;
    set_fields(1'b0, 3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    drive;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL i_latency_early got out_valid=%b want 0", out_valid); end
    @(negedge clk);
    tests++;
    if ({out_valid, out_inst, out_addr} !== {1'b1, 32'hFFF0_0093, BASE}) begin
      fails++; $display("FAIL i_type got v=%b inst=%h addr=%h want v=1 inst=fff00093 addr=%h", out_valid, out_inst, out_addr, BASE);
    end
  endtask

  task automatic test_back_to_back;
    pulse_clr;
    out_ready = 1'b1;
    set_fields(1'b0, 3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    drive;
    set_fields(1'b0, 3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    drive;
    wait_out;
    tests++; if ({out_inst, out_addr} !== {32'h0020_A423, BASE}) begin
      fails++; $display("FAIL b2b_store got inst=%h addr=%h want 0020a423 %h", out_inst, out_addr, BASE); end
    wait_out;
    tests++; if ({out_inst, out_addr} !== {32'h0010_00EF, BASE + 32'd4}) begin
      fails++; $display("FAIL b2b_jal got inst=%h addr=%h want 001000ef %h", out_inst, out_addr, BASE + 32'd4); end
  endtask

  task automatic test_b_u;
    pulse_clr;
    out_ready = 1'b1;
    set_fields(1'b0, 3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    drive;
    set_fields(1'b0, 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    drive;
    wait_out;
    tests++; if (out_inst !== 32'hFE00_0EE3) begin fails++; $display("FAIL branch got %h want fe000ee3", out_inst); end
    wait_out;
    tests++; if (out_inst !== 32'h1234_52B7) begin fails++; $display("FAIL lui got %h want 123452b7", out_inst); end
  endtask

  task automatic test_error;
    pulse_clr;
    out_ready = 1'b1;
    set_fields(1'b0, 3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    drive;
    @(negedge clk);
    @(negedge clk);
    tests++; if ({halted, err_count, in_ready, out_valid} !== {1'b1, 8'd1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL err_halt got halted=%b cnt=%0d in_ready=%b out_valid=%b want 1 1 0 0", halted, err_count, in_ready, out_valid); end
    tests++; if ({ne_out_valid, ne_out_err, ne_out_inst, ne_out_addr} !== {1'b1, 1'b1, 32'h0000_0163, NE_BASE}) begin
      fails++; $display("FAIL err_noStop_emit got v=%b e=%b inst=%h addr=%h want 1 1 00000163 c", ne_out_valid, ne_out_err, ne_out_inst, ne_out_addr); end
    tests++; if ({ne_halted, ne_err_count} !== {1'b0, 8'd1}) begin
      fails++; $display("FAIL err_noStop_state got halted=%b cnt=%0d want 0 1", ne_halted, ne_err_count); end
    @(negedge clk);
    tests++; if (ne_out_addr !== 4'h0) begin fails++; $display("FAIL addr_wrap got %h want 0", ne_out_addr); end
    set_fields(1'b0, 3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({in_ready, halted, out_valid} !== 3'b010) begin
      fails++; $display("FAIL halt_hold got in_ready=%b halted=%b out_valid=%b want 0 1 0", in_ready, halted, out_valid); end
    in_valid = 1'b0;
    pulse_clr;
    @(negedge clk);
    tests++; if ({halted, err_count} !== {1'b0, 8'd0}) begin
      fails++; $display("FAIL clr_resume got halted=%b cnt=%0d want 0 0", halted, err_count); end
    drive;
    wait_out;
    tests++; if ({out_inst, out_addr, out_err} !== {32'hFFF0_0093, BASE, 1'b0}) begin
      fails++; $display("FAIL after_clr got inst=%h addr=%h err=%b want fff00093 %h 0", out_inst, out_addr, out_err, BASE); end
  endtask

  task automatic test_bounds;
    bnd = '{
      '{1'b0, 3'd0, 32'h0000_07FF, 1'b0}, '{1'b0, 3'd0, 32'h0000_0800, 1'b1},
      '{1'b0, 3'd0, 32'hFFFF_F800, 1'b0}, '{1'b0, 3'd0, 32'hFFFF_F7FF, 1'b1},
      '{1'b0, 3'd1, 32'h0000_07FF, 1'b0}, '{1'b0, 3'd1, 32'hFFFF_F7FF, 1'b1},
      '{1'b0, 3'd2, 32'h0000_0FFE, 1'b0}, '{1'b0, 3'd2, 32'h0000_1000, 1'b1},
      '{1'b0, 3'd2, 32'hFFFF_F000, 1'b0}, '{1'b0, 3'd2, 32'hFFFF_EFFE, 1'b1},
      '{1'b0, 3'd2, 32'h0000_0005, 1'b1}, '{1'b0, 3'd3, 32'h000F_FFFE, 1'b0},
      '{1'b0, 3'd3, 32'h0010_0000, 1'b1}, '{1'b0, 3'd3, 32'hFFF0_0000, 1'b0},
      '{1'b0, 3'd3, 32'h0000_0007, 1'b1}, '{1'b0, 3'd4, 32'hFFFF_F000, 1'b0},
      '{1'b0, 3'd4, 32'h0000_0800, 1'b1}, '{1'b0, 3'd5, 32'h0000_0000, 1'b1},
      '{1'b1, 3'd7, 32'h0000_0003, 1'b0}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      pulse_clr;
      set_fields(bnd[i].r, bnd[i].sel, 7'h13, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, bnd[i].imm);
      drive;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({ne_out_valid, ne_out_err, halted} !== {1'b1, bnd[i].bad, bnd[i].bad}) begin
        fails++; $display("FAIL bound_%0d sel=%0d imm=%h got v=%b err=%b halted=%b want 1 %b %b",
                          i, bnd[i].sel, bnd[i].imm, ne_out_valid, ne_out_err, halted, bnd[i].bad, bnd[i].bad);
      end
    end
    pulse_clr;
  endtask

  task automatic load_entry(input int k);
    case (k)
      0: set_fields(1'b0, 3'd0, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5);
      1: set_fields(1'b1, 3'd2, 7'h33, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 32'hDEAD_BEEF);
      default: set_fields(1'b0, 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000);
    endcase
  endtask

  task automatic test_backpressure;
    logic [31:0] want [3];
    int acc, got, n;
    bit rdy;
    want = '{32'h0051_8113, 32'h4053_03B3, 32'hFFFF_F0B7};
    pulse_clr;
    out_ready = 1'b0;
    acc = 0;
    load_entry(0);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        tests++;
        if ({out_valid, out_inst, out_addr} !== {1'b1, want[0], BASE}) begin
          fails++; $display("FAIL bp_hold_c%0d got v=%b inst=%h addr=%h want 1 %h %h", c, out_valid, out_inst, out_addr, want[0], BASE);
        end
      end
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin acc++; load_entry(acc); end
    end
    @(negedge clk);
    tests++; if ({acc, in_ready} !== {32'd2, 1'b0}) begin
      fails++; $display("FAIL bp_accept got acc=%0d in_ready=%b want 2 0", acc, in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 3 && n < 30) begin
      @(negedge clk); n++;
      rdy = in_ready;
      if (out_valid) begin
        tests++;
        if ({out_inst, out_addr} !== {want[got], BASE + 32'(4 * got)}) begin
          fails++; $display("FAIL bp_drain_%0d got inst=%h addr=%h want %h %h", got, out_inst, out_addr, want[got], BASE + 32'(4 * got));
        end
        got++;
      end
      @(posedge clk); #1;
      if (rdy && in_valid) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tests++; if (got != 3) begin fails++; $display("FAIL bp_drain_count got %0d want 3", got); end
  endtask

  function automatic logic [31:0] imm_gen(input logic [2:0] k, input logic [31:0] w);
    case (k)
      3'd0: imm_gen = {{20{w[31]}}, w[31:20]};
      3'd1: imm_gen = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2: imm_gen = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3: imm_gen = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm_gen = {w[31:12], 12'b0};
    endcase
  endfunction

  task automatic test_random;
    pulse_clr;
    q.delete();
    fork
      begin : driver
        exp_t e;
        logic [31:0] rnd;
        int n;
        bit rdy;
        for (int i = 0; i < NRAND; i++) begin
          e.kind = 3'($urandom_range(0, 5));
          rnd = $urandom();
          case (e.kind)
            3'd0: begin e.imm = 32'(int'($urandom_range(0, 4095)) - 2048); e.op = 7'h13; end
            3'd1: begin e.imm = 32'(int'($urandom_range(0, 4095)) - 2048); e.op = 7'h23; end
            3'd2: begin e.imm = 32'(int'($urandom_range(0, 4095)) * 2 - 4096); e.op = 7'h63; end
            3'd3: begin e.imm = 32'(int'($urandom_range(0, 20'hFFFFF)) * 2 - (1 << 20)); e.op = 7'h6F; end
            3'd4: begin e.imm = {rnd[31:12], 12'b0}; e.op = 7'h37; end
            default: begin e.imm = rnd; e.op = 7'h33; end
          endcase
          rnd = $urandom();
          set_fields(e.kind == 3'd5, (e.kind == 3'd5) ? 3'd0 : e.kind, e.op, rnd[4:0], rnd[9:5],
                     rnd[14:10], rnd[17:15], rnd[24:18], e.imm);
          e.word = {rnd[24:18], rnd[14:10], rnd[9:5], rnd[17:15], rnd[4:0], e.op};
          in_valid = 1'b1;
          n = 0;
          do begin @(negedge clk); rdy = in_ready; @(posedge clk); #1; n++; end while (!rdy && n < 100);
          if (!rdy) begin tests++; fails++; $display("FAIL rand_accept_timeout entry %0d", i); in_valid = 1'b0; break; end
          q.push_back(e);
          in_valid = 1'b0;
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        in_valid = 1'b0;
      end
      begin : monitor
        exp_t e;
        logic [31:0] exp_addr;
        int got, cyc;
        bit ok;
        got = 0; cyc = 0; exp_addr = BASE;
        while (got < NRAND && cyc < 60000) begin
          @(negedge clk); cyc++;
          if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
              fails++; $display("FAIL rand_unexpected_output got inst=%h want none", out_inst);
            end else begin
              e = q.pop_front();
              if (e.kind == 3'd5) ok = ({out_inst, out_addr} === {e.word, exp_addr});
              else ok = ({imm_gen(e.kind, out_inst), out_inst[6:0], out_addr} === {e.imm, e.op, exp_addr});
              if (!ok) begin
                fails++; $display("FAIL rand_%0d kind=%0d got inst=%h imm=%h addr=%h want imm=%h word=%h addr=%h",
                                  got, e.kind, out_inst, imm_gen(e.kind, out_inst), out_addr, e.imm, e.word, exp_addr);
              end
            end
            exp_addr = exp_addr + 32'd4;
            got++;
          end
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        tests++; if (got != NRAND) begin fails++; $display("FAIL rand_count got %0d want %0d", got, NRAND); end
      end
    join
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    pulse_clr;
    out_ready = 1'b0;
    load_entry(0);
    drive;
    load_entry(1);
    drive;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_prefill got out_valid=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({out_valid, out_inst, out_err, halted, err_count, out_addr} !== {1'b0, 32'h0, 1'b0, 1'b0, 8'd0, BASE}) begin
      fails++; $display("FAIL mid_reset_now got v=%b inst=%h err=%b halted=%b cnt=%0d addr=%h want 0 0 0 0 0 %h",
                        out_valid, out_inst, out_err, halted, err_count, out_addr, BASE); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL mid_lost got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset;
    test_i_type;
    test_back_to_back;
    test_b_u;
    test_error;
    test_bounds;
    test_backpressure;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
